// File: rtl/ptw_pkg.sv
// Shared types for the Sv39 page-table walker: FSM states, PTE and TLB-update layouts,
// and the PTE address helper.
package ptw_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DRAIN} ptw_state_e;

  localparam int PTE_SIZE_LOG2 = 3;
  localparam int SV39_LEVELS   = 3;
  localparam int VPN_W         = 9;
  localparam int PPN_W         = 44;
  localparam int PADDR_W       = 56;
  localparam int TLB_ASID_W    = 16;

  typedef struct packed {
    logic [9:0]       reserved;
    logic [PPN_W-1:0] ppn;
    logic [1:0]       rsw;
    logic             d;
    logic             a;
    logic             g;
    logic             u;
    logic             x;
    logic             w;
    logic             r;
    logic             v;
  } pte_t;

  typedef struct packed {
    logic                  valid;
    logic                  is_2M;
    logic                  is_1G;
    logic [26:0]           vpn;
    logic [TLB_ASID_W-1:0] asid;
    pte_t                  content;
  } tlb_update_t;

  function automatic logic [VPN_W-1:0] vpn_sel(input logic [63:0] va, input logic [1:0] lvl);
    case (lvl)
      2'd2:    return va[38:30];
      2'd1:    return va[29:21];
      default: return va[20:12];
    endcase
  endfunction

  function automatic logic [PADDR_W-1:0] pte_addr(input logic [PPN_W-1:0] ppn,
                                                  input logic [63:0] va, input logic [1:0] lvl);
    return {ppn, vpn_sel(va, lvl), {PTE_SIZE_LOG2{1'b0}}};
  endfunction

endpackage

// File: rtl/ptw_pte_check.sv
// Combinational PTE classifier: leaf detection and fault detection for a given walk level.
// Optional software-managed A/D checking is enabled with PTW_AD_CHECK_EN.
module ptw_pte_check
  import ptw_pkg::*;
(
  input  pte_t       pte,
  input  logic [1:0] level,
  output logic       is_leaf,
  output logic       is_fault
);

  logic misaligned;

  always_comb begin
    is_leaf    = pte.r | pte.x;
    misaligned = (level == 2'd2 && pte.ppn[17:0] != '0) ||
                 (level == 2'd1 && pte.ppn[8:0]  != '0);
    is_fault   = !pte.v || (!pte.r && pte.w) ||
                 (!is_leaf && level == 2'd0) || (is_leaf && misaligned);
`ifdef PTW_AD_CHECK_EN
    // A/D are maintained by software, so a leaf needing an A/D update must trap
    if (is_leaf && (!pte.a || (!pte.d && pte.w)))
      is_fault = 1'b1;
`else
`endif
  end

endmodule

// File: rtl/sv39_ptw.sv
// Sv39 hardware page-table walker: one miss at a time, single-outstanding PTE reads,
// one-cycle TLB fill or page-fault pulse. Optional A/D check: PTW_AD_CHECK_EN.
module sv39_ptw
  import ptw_pkg::*;
#(
  parameter int unsigned ASID_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [63:0]           req_vaddr_i,
  input  logic [ASID_WIDTH-1:0] req_asid_i,
  input  logic [43:0]           satp_ppn_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [55:0]           mem_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [63:0]           mem_rsp_data_i,
  output tlb_update_t           update_o,
  output logic                  fault_o,
  output logic [63:0]           fault_vaddr_o
);

  ptw_state_e            state_q;
  logic [1:0]            level_q;
  logic [63:0]           vaddr_q;
  logic [ASID_WIDTH-1:0] asid_q;
  pte_t                  pte;
  logic                  is_leaf, is_fault, rsp_hit;

  assign pte = mem_rsp_data_i;

  ptw_pte_check u_pte_check (
    .pte      (pte),
    .level    (level_q),
    .is_leaf  (is_leaf),
    .is_fault (is_fault)
  );

  // A response landing in the same cycle as a flush belongs to the aborted walk
  assign rsp_hit     = (state_q == WAIT_RSP) && mem_rsp_valid_i && !flush_i;
  assign req_ready_o = (state_q == IDLE) && !flush_i;
  assign fault_o     = rsp_hit && is_fault;

  always_comb begin
    update_o = '0;
    if (rsp_hit && is_leaf && !is_fault) begin
      update_o.valid   = 1'b1;
      update_o.is_1G   = (level_q == 2'd2);
      update_o.is_2M   = (level_q == 2'd1);
      update_o.vpn     = vaddr_q[38:12];
      update_o.asid    = TLB_ASID_W'(asid_q);
      update_o.content = pte;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      level_q         <= 2'd2;
      vaddr_q         <= '0;
      asid_q          <= '0;
      mem_req_valid_o <= 1'b0;
      mem_addr_o      <= '0;
      fault_vaddr_o   <= '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i && !flush_i) begin
          vaddr_q         <= req_vaddr_i;
          asid_q          <= req_asid_i;
          level_q         <= 2'd2;
          mem_addr_o      <= pte_addr(satp_ppn_i, req_vaddr_i, 2'd2);
          mem_req_valid_o <= 1'b1;
          state_q         <= ISSUE;
        end
        ISSUE: begin
          if (flush_i) begin
            // an accepted request still owes us a response
            mem_req_valid_o <= 1'b0;
            state_q         <= mem_req_ready_i ? DRAIN : IDLE;
          end else if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state_q         <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (mem_rsp_valid_i) begin
            if (flush_i || is_leaf || is_fault) begin
              state_q <= IDLE;
            end else begin
              level_q         <= level_q - 2'd1;
              mem_addr_o      <= pte_addr(pte.ppn, vaddr_q, level_q - 2'd1);
              mem_req_valid_o <= 1'b1;
              state_q         <= ISSUE;
            end
            if (!flush_i && is_fault)
              fault_vaddr_o <= vaddr_q;
          end else if (flush_i) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: if (mem_rsp_valid_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sv39_ptw.sv
// Directed bench for sv39_ptw: table of walks with hand-computed addresses/results,
// plus hand-written flush, back-pressure and stray-response sequences.
module tb_sv39_ptw;
  import ptw_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, req_asid;
  logic [63:0] req_vaddr;
  logic [43:0] satp;
  logic        mem_req_valid, mem_req_ready, mem_rsp_valid, fault;
  logic [55:0] mem_addr;
  logic [63:0] mem_rsp_data, fault_vaddr;
  tlb_update_t update;

  sv39_ptw #(.ASID_WIDTH(1)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_vaddr_i(req_vaddr), .req_asid_i(req_asid), .satp_ppn_i(satp),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_addr_o(mem_addr),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rsp_data_i(mem_rsp_data),
    .update_o(update), .fault_o(fault), .fault_vaddr_o(fault_vaddr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [43:0]      satp;
    logic [63:0]      va;
    logic             asid;
    logic [2:0][63:0] pte;
    logic [2:0][55:0] addr;
    int               nreads;
    bit               upd, flt, m2, g1;
    logic [26:0]      vpn;
  } vec_t;

  function automatic logic [63:0] mk_pte(input logic [43:0] ppn, input logic [7:0] fl);
    return {10'b0, ppn, 2'b00, fl};
  endfunction

  function automatic vec_t mk(input logic [43:0] s, input logic [63:0] va, input logic asid,
                              input logic [63:0] p0, p1, p2, input logic [55:0] a0, a1, a2,
                              input int nr, input bit upd, flt, m2, g1, input logic [26:0] vpn);
    vec_t r;
    r.satp = s; r.va = va; r.asid = asid;
    r.pte[0] = p0; r.pte[1] = p1; r.pte[2] = p2;
    r.addr[0] = a0; r.addr[1] = a1; r.addr[2] = a2;
    r.nreads = nr; r.upd = upd; r.flt = flt; r.m2 = m2; r.g1 = g1; r.vpn = vpn;
    return r;
  endfunction

  localparam int NV = 10;
  localparam logic [63:0] VA1 = 64'h0000_0040_2012_3000;  // vpn2=0x100 vpn1=0x100 vpn0=0x123
  localparam logic [63:0] VA2 = 64'h0000_0001_C000_0000;  // vpn2=0x7
  vec_t vecs [NV];
  vec_t v;
  tlb_update_t cap;
  int nupd, nflt, wcnt;
  logic [63:0] p_l2, p_l1;

  initial begin
    p_l2 = mk_pte(44'h200, 8'h01);
    p_l1 = mk_pte(44'h300, 8'h01);
    vecs[0] = mk(44'h100, VA1, 1'b0, p_l2, p_l1, mk_pte(44'h12345, 8'hCF),
                 56'h100800, 56'h200800, 56'h300918, 3, 1, 0, 0, 0, 27'h4020123);
    vecs[1] = mk(44'h100, VA1, 1'b0, p_l2, mk_pte(44'h400, 8'hCF), 64'h0,
                 56'h100800, 56'h200800, 56'h0, 2, 1, 0, 1, 0, 27'h4020123);
    vecs[2] = mk(44'h100, VA1, 1'b0, p_l2, mk_pte(44'h401, 8'hCF), 64'h0,
                 56'h100800, 56'h200800, 56'h0, 2, 0, 1, 0, 0, 27'h0);
    vecs[3] = mk(44'h100, VA1, 1'b0, 64'h0, 64'h0, 64'h0,
                 56'h100800, 56'h0, 56'h0, 1, 0, 1, 0, 0, 27'h0);
    vecs[4] = mk(44'h55, VA2, 1'b1, mk_pte(44'h40000, 8'hCF), 64'h0, 64'h0,
                 56'h55038, 56'h0, 56'h0, 1, 1, 0, 0, 1, 27'h1C0000);
    vecs[5] = mk(44'h55, VA2, 1'b1, mk_pte(44'h40001, 8'hCF), 64'h0, 64'h0,
                 56'h55038, 56'h0, 56'h0, 1, 0, 1, 0, 0, 27'h0);
    vecs[6] = mk(44'h100, VA1, 1'b0, mk_pte(44'h200, 8'h05), 64'h0, 64'h0,
                 56'h100800, 56'h0, 56'h0, 1, 0, 1, 0, 0, 27'h0);
    vecs[7] = mk(44'h100, VA1, 1'b0, p_l2, p_l1, mk_pte(44'h500, 8'h01),
                 56'h100800, 56'h200800, 56'h300918, 3, 0, 1, 0, 0, 27'h0);
`ifdef PTW_AD_CHECK_EN
    vecs[8] = mk(44'h100, VA1, 1'b0, p_l2, p_l1, mk_pte(44'h777, 8'h8F),
                 56'h100800, 56'h200800, 56'h300918, 3, 0, 1, 0, 0, 27'h0);
`else
    vecs[8] = mk(44'h100, VA1, 1'b0, p_l2, p_l1, mk_pte(44'h777, 8'h8F),
                 56'h100800, 56'h200800, 56'h300918, 3, 1, 0, 0, 0, 27'h4020123);
`endif
    vecs[9] = mk(44'h100, VA1, 1'b1, p_l2, p_l1, mk_pte(44'h888, 8'h49),
                 56'h100800, 56'h200800, 56'h300918, 3, 1, 0, 0, 0, 27'h4020123);

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_asid = 1'b0; satp = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_memvalid", 64'(mem_req_valid), 64'd0);
    chk("rst_update", 64'(update), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_fvaddr", fault_vaddr, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge clk);
      req_valid = 1'b1; req_vaddr = v.va; req_asid = v.asid; satp = v.satp;
      #1 chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
      nupd = 0; nflt = 0; cap = '0;
      for (int k = 0; k < v.nreads; k++) begin
        wcnt = 0;
        while (!mem_req_valid && wcnt < 20) begin @(negedge clk); wcnt++; end
        chk($sformatf("v%0d_lat%0d", i, k), 64'(wcnt), 64'd0);
        chk($sformatf("v%0d_addr%0d", i, k), 64'(mem_addr), 64'(v.addr[k]));
        @(negedge clk);
        mem_rsp_valid = 1'b1; mem_rsp_data = v.pte[k];
        #1;
        if (update.valid) begin nupd++; cap = update; end
        if (fault) nflt++;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
      end
      #1;
      chk($sformatf("v%0d_idle", i), 64'(req_ready), 64'd1);
      chk($sformatf("v%0d_noreq", i), 64'(mem_req_valid), 64'd0);
      chk($sformatf("v%0d_nupd", i), 64'(nupd), 64'(v.upd));
      chk($sformatf("v%0d_nflt", i), 64'(nflt), 64'(v.flt));
      if (v.upd) begin
        chk($sformatf("v%0d_vpn", i), 64'(cap.vpn), 64'(v.vpn));
        chk($sformatf("v%0d_2M", i), 64'(cap.is_2M), 64'(v.m2));
        chk($sformatf("v%0d_1G", i), 64'(cap.is_1G), 64'(v.g1));
        chk($sformatf("v%0d_asid", i), 64'(cap.asid), 64'(v.asid));
        chk($sformatf("v%0d_content", i), 64'(cap.content), v.pte[v.nreads-1]);
      end
      if (v.flt) chk($sformatf("v%0d_fvaddr", i), fault_vaddr, v.va);
    end

    // flush while waiting for the response; late response must be swallowed
    @(negedge clk);
    req_valid = 1'b1; req_vaddr = VA2; req_asid = 1'b0; satp = 44'h100;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    nupd = 0; nflt = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (update.valid) nupd++;
      if (fault) nflt++;
      chk("flush_wait_noreq", 64'(mem_req_valid), 64'd0);
    end
    mem_rsp_valid = 1'b1; mem_rsp_data = mk_pte(44'h40000, 8'hCF);
    #1;
    if (update.valid) nupd++;
    if (fault) nflt++;
    chk("flush_drain_busy", 64'(req_ready), 64'd0);
    chk("flush_nupd", 64'(nupd), 64'd0);
    chk("flush_nflt", 64'(nflt), 64'd0);
    @(negedge clk); mem_rsp_valid = 1'b0;
    #1 chk("flush_idle", 64'(req_ready), 64'd1);

    // flush in ISSUE before the handshake drops the request
    mem_req_ready = 1'b0;
    @(negedge clk); req_valid = 1'b1; req_vaddr = VA1;
    @(negedge clk); req_valid = 1'b0; flush = 1'b1;
    #1 chk("fiss_valid_before", 64'(mem_req_valid), 64'd1);
    @(negedge clk); flush = 1'b0;
    #1 chk("fiss_dropped", 64'(mem_req_valid), 64'd0);
    chk("fiss_idle", 64'(req_ready), 64'd1);
    mem_req_ready = 1'b1;

    // flush together with a request in IDLE: not accepted
    @(negedge clk); req_valid = 1'b1; flush = 1'b1;
    #1 chk("fidle_ready", 64'(req_ready), 64'd0);
    @(negedge clk); req_valid = 1'b0; flush = 1'b0;
    #1 chk("fidle_noreq", 64'(mem_req_valid), 64'd0);

    // stray response while idle
    @(negedge clk); mem_rsp_valid = 1'b1; mem_rsp_data = mk_pte(44'h40000, 8'hCF);
    #1 chk("stray_upd", 64'(update.valid), 64'd0);
    chk("stray_flt", 64'(fault), 64'd0);
    @(negedge clk); mem_rsp_valid = 1'b0;
    #1 chk("stray_noreq", 64'(mem_req_valid), 64'd0);

    // memory back-pressure: address held, one request, then L2 invalid fault
    mem_req_ready = 1'b0;
    @(negedge clk); req_valid = 1'b1; req_vaddr = VA1; satp = 44'h100;
    @(negedge clk); req_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("bp_valid%0d", c), 64'(mem_req_valid), 64'd1);
      chk($sformatf("bp_addr%0d", c), 64'(mem_addr), 64'h100800);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    #1 chk("bp_single", 64'(mem_req_valid), 64'd0);
    mem_rsp_valid = 1'b1; mem_rsp_data = 64'h0;
    #1 chk("bp_fault", 64'(fault), 64'd1);
    chk("bp_noupd", 64'(update.valid), 64'd0);
    @(negedge clk); mem_rsp_valid = 1'b0;
    #1 chk("bp_fvaddr", fault_vaddr, VA1);
    chk("bp_idle", 64'(req_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
